sample_sweep_ctrl: RTL

SAMPLE_SWEEP_CTRL -- requirements
Module: sample_sweep_ctrl

---
 rtl/sample_sweep_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sample_sweep_ctrl.sv
// Constrained-random sample sweeper: drives LFSR candidates to a combinational
// checker, waits a settle time, and streams satisfying candidates out.
module sample_sweep_ctrl #(
    parameter int CAND_W = 32,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CAND_W-1:0] seed,
    input  logic [15:0]       target_count,
    input  logic [31:0]       max_attempts,
    output logic [CAND_W-1:0] cand,
    input  logic              chk_x,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic [CAND_W-1:0] smp_data,
    output logic              busy,
    output logic              done,
    output logic              exhausted,
    output logic [15:0]       hit_count,
    output logic [31:0]       attempt_count
);

    // state  | meaning
    // IDLE   | no sweep, waiting for start
    // DRIVE  | present next LFSR value on cand, count the attempt
    // WAIT   | let the checker settle, sample chk_x on the last settle cycle
    // EMIT   | hold a satisfying sample until the consumer accepts it
    // DONE   | sweep finished; results hold until the next start
    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [CAND_W-1:0] LFSR_MASK   = CAND_W'(32'h80200003);
    localparam logic [3:0]        SETTLE_INIT = 4'(SETTLE);

    state_t            state;
    state_t            state_nxt;
    logic [CAND_W-1:0] lfsr;
    logic [CAND_W-1:0] lfsr_step;
    logic [15:0]       tgt_r;
    logic [31:0]       max_r;
    logic [3:0]        settle_cnt;
    logic              budget_out;

    logic do_start;
    logic do_drive;
    logic do_adv;
    logic do_hit;
    logic do_hs;
    logic do_exh;
    logic enter_done;

    assign lfsr_step  = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : '0);
    assign budget_out = (max_r != 32'd0) && (attempt_count == max_r);
    assign busy       = (state == S_DRIVE) || (state == S_WAIT) || (state == S_EMIT);

    always_comb begin
        state_nxt  = state;
        do_start   = 1'b0;
        do_drive   = 1'b0;
        do_adv     = 1'b0;
        do_hit     = 1'b0;
        do_hs      = 1'b0;
        do_exh     = 1'b0;
        enter_done = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        do_start = 1'b1;
                        if (target_count == 16'd0) begin
                            state_nxt  = S_DONE;
                            enter_done = 1'b1;
                        end else begin
                            state_nxt = S_DRIVE;
                        end
                    end
                end
                S_DRIVE: begin
                    do_drive  = 1'b1;
                    state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (settle_cnt == 4'd1) begin
                        do_adv = 1'b1;
                        if (chk_x) begin
                            do_hit    = 1'b1;
                            state_nxt = S_EMIT;
                        end else if (budget_out) begin
                            do_exh     = 1'b1;
                            enter_done = 1'b1;
                            state_nxt  = S_DONE;
                        end else begin
                            state_nxt = S_DRIVE;
                        end
                    end
                end
                S_EMIT: begin
                    if (smp_valid && smp_ready) begin
                        do_hs = 1'b1;
                        // reaching the target wins over a simultaneously spent budget
                        if (hit_count + 16'd1 == tgt_r) begin
                            enter_done = 1'b1;
                            state_nxt  = S_DONE;
                        end else if (budget_out) begin
                            do_exh     = 1'b1;
                            enter_done = 1'b1;
                            state_nxt  = S_DONE;
                        end else begin
                            state_nxt = S_DRIVE;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            lfsr          <= '0;
            cand          <= '0;
            smp_data      <= '0;
            smp_valid     <= 1'b0;
            done          <= 1'b0;
            exhausted     <= 1'b0;
            hit_count     <= 16'd0;
            attempt_count <= 32'd0;
            tgt_r         <= 16'd0;
            max_r         <= 32'd0;
            settle_cnt    <= 4'd0;
        end else begin
            state <= state_nxt;
            done  <= enter_done;
            if (do_start) begin
                tgt_r         <= target_count;
                max_r         <= max_attempts;
                lfsr          <= (seed == '0) ? CAND_W'(1) : seed;
                hit_count     <= 16'd0;
                attempt_count <= 32'd0;
                exhausted     <= 1'b0;
            end
            if (do_drive) begin
                cand       <= lfsr;
                settle_cnt <= SETTLE_INIT;
                if (attempt_count != 32'hFFFF_FFFF) begin
                    attempt_count <= attempt_count + 32'd1;
                end
            end
            if (state == S_WAIT && !abort) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (do_adv) begin
                lfsr <= lfsr_step;
            end
            if (do_hit) begin
                smp_data  <= cand;
                smp_valid <= 1'b1;
            end
            if (do_hs) begin
                smp_valid <= 1'b0;
                hit_count <= hit_count + 16'd1;
            end
            if (do_exh) begin
                exhausted <= 1'b1;
            end
            if (abort) begin
                smp_valid <= 1'b0;
            end
        end
    end

endmodule
